// File: rtl/ir_queue_if.sv
// ir_queue_if: fetch/decode bundle for the instruction-register queue.
// Fetch side: flush, in_valid/in_ready, in, pc_in.
// Decode side: out_valid/out_ready, pc_out, decoded LC-3b fields, count.
// slave is the queue's view; master is the fetch/decode (or bench) view.
interface ir_queue_if #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [15:0]         in;
    logic [PC_WIDTH-1:0] pc_in;
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] pc_out;
    logic [3:0]          opcode;
    logic [2:0]          dest;
    logic [2:0]          src1;
    logic [2:0]          src2;
    logic [4:0]          imm5;
    logic [3:0]          imm4;
    logic [5:0]          offset6;
    logic [8:0]          offset9;
    logic [10:0]         offset11;
    logic [7:0]          trapvect8;
    logic                jsr_check;
    logic [CW-1:0]       count;

    modport slave (
        input  flush, in_valid, in, pc_in, out_ready,
        output in_ready, out_valid, pc_out,
        output opcode, dest, src1, src2,
        output imm5, imm4, offset6, offset9,
        output offset11, trapvect8, jsr_check,
        output count
    );

    modport master (
        output flush, in_valid, in, pc_in, out_ready,
        input  in_ready, out_valid, pc_out,
        input  opcode, dest, src1, src2,
        input  imm5, imm4, offset6, offset9,
        input  offset11, trapvect8, jsr_check,
        input  count
    );
endinterface

// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry circular buffer of {instruction word, PC} between
// fetch and decode, exposing decoded LC-3b fields of the head entry.
// Ports: clk, reset (async, active-high), bus (ir_queue_if.slave).
// Optional macro IR_QUEUE_BYPASS_EN: an empty queue presents the incoming
// word in the same cycle; without it there is no in->out combinational path.
module ir_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    ir_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]         r_word [DEPTH];
    logic [PC_WIDTH-1:0] r_pc   [DEPTH];
    logic [AW-1:0]       r_rd;
    logic [AW-1:0]       r_wr;
    logic [CW-1:0]       r_count;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_store;
    logic                w_pop;
    logic                w_out_valid;
    logic [15:0]         w_head;
    logic [PC_WIDTH-1:0] w_head_pc;
    logic [15:0]         w_hw;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // No pass-through on full: in_ready ignores a same-cycle pop.
    assign bus.in_ready = !w_full;
    assign w_push       = bus.in_valid && !w_full;

`ifdef IR_QUEUE_BYPASS_EN
    logic w_byp;
    assign w_byp       = w_empty && bus.in_valid && !bus.flush;
    assign w_out_valid = (!w_empty || w_byp) && !bus.flush;
    assign w_head      = w_byp ? bus.in : r_word[r_rd];
    assign w_head_pc   = w_byp ? bus.pc_in : r_pc[r_rd];
    // A bypassed word taken by decode is never written.
    assign w_store = w_push && !(w_byp && bus.out_ready);
    assign w_pop   = w_out_valid && bus.out_ready && !w_empty;
`else
    assign w_out_valid = !w_empty && !bus.flush;
    assign w_head      = r_word[r_rd];
    assign w_head_pc   = r_pc[r_rd];
    assign w_store     = w_push;
    assign w_pop       = w_out_valid && bus.out_ready;
`endif

    assign bus.out_valid = w_out_valid;
    assign bus.count     = r_count;

    // Fields read as zero whenever the head is not valid.
    assign w_hw          = w_out_valid ? w_head : '0;
    assign bus.pc_out    = w_out_valid ? w_head_pc : '0;
    assign bus.opcode    = w_hw[15:12];
    assign bus.dest      = w_hw[11:9];
    assign bus.src1      = w_hw[8:6];
    assign bus.src2      = w_hw[2:0];
    assign bus.imm5      = w_hw[4:0];
    assign bus.imm4      = w_hw[3:0];
    assign bus.offset6   = w_hw[5:0];
    assign bus.offset9   = w_hw[8:0];
    assign bus.offset11  = w_hw[10:0];
    assign bus.trapvect8 = w_hw[7:0];
    assign bus.jsr_check = w_hw[11];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_store) r_wr <= r_wr + 1'b1;
            if (w_pop)   r_rd <= r_rd + 1'b1;
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: nothing is visible until counted.
    always_ff @(posedge clk) begin
        if (w_store && !bus.flush) begin
            r_word[r_wr] <= bus.in;
            r_pc[r_wr]   <= bus.pc_in;
        end
    end
endmodule
